bs_rotate_right: RTL and testbench

BS_ROTATE_RIGHT -- requirements
Module: bs_rotate_right

---
 rtl/bs_rotate_right.sv | 91 +++++++++
 tb/tb_bs_rotate_right.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/bs_rotate_right.sv
// -----------------------------------------------------------------------------
// bs_rotate_right
//   Registered rotate-right built as a logarithmic barrel shifter. Stage s
//   rotates its input right by 2^s positions when i_k[s] is set and passes the
//   data through unchanged otherwise. The final stage output is captured in the
//   output register whenever i_vld is high, giving a fixed one-cycle latency.
//
// Parameters
//   WIDTH : data width, a power of two, 2 or greater
//   SHW   : width of the rotate amount, defaults to $clog2(WIDTH)
//
// Ports
//   i_clk  in   1      rising-edge clock
//   i_rst  in   1      asynchronous active-high reset
//   i_vld  in   1      i_A / i_k valid this cycle
//   i_A    in   WIDTH  data word to rotate
//   i_k    in   SHW    rotate-right amount (taken modulo WIDTH)
//   o_Y    out  WIDTH  registered rotated result
//   o_vld  out  1      o_Y holds a result captured on the previous edge
// -----------------------------------------------------------------------------
module bs_rotate_right #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_vld,
  input  logic [WIDTH-1:0] i_A,
  input  logic [SHW-1:0]   i_k,
  output logic [WIDTH-1:0] o_Y,
  output logic             o_vld
);

  // stage_s[0] is the raw input; stage_s[SHW] is the fully rotated word.
  logic [WIDTH-1:0] stage_s [0:SHW];

  logic [WIDTH-1:0] y_d;
  logic [WIDTH-1:0] y_q;
  logic             vld_d;
  logic             vld_q;

  assign stage_s[0] = i_A;

  for (genvar s = 0; s < SHW; s++) begin : g_stage
    // Reducing the stage amount modulo WIDTH keeps any extra high bits of
    // i_k legal: they simply rotate by a full multiple of WIDTH.
    localparam int unsigned AMT = (32'd1 << s) % WIDTH;

    logic [WIDTH-1:0] rot_s;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      // Rotate right: result bit i takes source bit (i + AMT) mod WIDTH, so
      // low bits wrap around into the top of the word.
      localparam int unsigned SRC = (i + AMT) % WIDTH;
      assign rot_s[i] = stage_s[s][SRC];
    end

    assign stage_s[s+1] = i_k[s] ? rot_s : stage_s[s];
  end

  // Next-state: load a new result on valid, otherwise hold and drop valid.
  // Holding y_q (rather than muxing in the datapath) keeps unknown inputs out
  // of the register while i_vld is low.
  always_comb begin
    y_d   = y_q;
    vld_d = 1'b0;
    if (i_vld) begin
      y_d   = stage_s[SHW];
      vld_d = 1'b1;
    end else begin
      y_d   = y_q;
      vld_d = 1'b0;
    end
  end

  // Output registers with asynchronous clear; reset discards any in-flight
  // result and release alone never raises o_vld.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      y_q   <= {WIDTH{1'b0}};
      vld_q <= 1'b0;
    end else begin
      y_q   <= y_d;
      vld_q <= vld_d;
    end
  end

  assign o_Y   = y_q;
  assign o_vld = vld_q;

endmodule

// File: tb/tb_bs_rotate_right.sv
// -----------------------------------------------------------------------------
// tb_bs_rotate_right
//   Directed and swept checks of bs_rotate_right at WIDTH = 4, 8 and 16.
//   Expected values are either hand-computed constants or come from a
//   bit-by-bit reference rotate written independently of the barrel stages.
// -----------------------------------------------------------------------------
module tb_bs_rotate_right;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        v4 = 1'b0;
  logic [3:0]  a4 = 4'd0;
  logic [1:0]  k4 = 2'd0;
  logic [3:0]  y4;
  logic        ov4;

  logic        v8 = 1'b0;
  logic [7:0]  a8 = 8'd0;
  logic [2:0]  k8 = 3'd0;
  logic [7:0]  y8;
  logic        ov8;

  logic        v16 = 1'b0;
  logic [15:0] a16 = 16'd0;
  logic [3:0]  k16 = 4'd0;
  logic [15:0] y16;
  logic        ov16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bs_rotate_right #(.WIDTH(4)) u_dut4 (
    .i_clk(clk), .i_rst(rst), .i_vld(v4), .i_A(a4), .i_k(k4),
    .o_Y(y4), .o_vld(ov4)
  );

  bs_rotate_right #(.WIDTH(8)) u_dut8 (
    .i_clk(clk), .i_rst(rst), .i_vld(v8), .i_A(a8), .i_k(k8),
    .o_Y(y8), .o_vld(ov8)
  );

  bs_rotate_right #(.WIDTH(16)) u_dut16 (
    .i_clk(clk), .i_rst(rst), .i_vld(v16), .i_A(a16), .i_k(k16),
    .o_Y(y16), .o_vld(ov16)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic check_val(input string tag, input logic [15:0] obs,
                           input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference rotate-right: bit i of the result is a[(i + k) mod w].
  function automatic logic [15:0] rot_ref(input logic [15:0] a, input int k,
                                          input int w);
    logic [15:0] r;
    r = 16'd0;
    for (int i = 0; i < w; i++) begin
      r[i] = a[(i + k) % w];
    end
    return r;
  endfunction

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Directed WIDTH=4 vector: apply, clock once, compare result and valid.
  task automatic dir4(input string tag, input logic [3:0] a, input logic [1:0] k,
                      input logic [3:0] exp);
    a4 = a; k4 = k; v4 = 1'b1;
    step();
    check_val(tag, {12'd0, y4}, {12'd0, exp});
    check_val({tag, "_vld"}, {15'd0, ov4}, 16'd1);
  endtask

  initial begin
    logic [3:0] ra4;
    logic [1:0] rk4;

    // Reset held: outputs cleared.
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_y4", {12'd0, y4}, 16'd0);
    check_val("rst_vld4", {15'd0, ov4}, 16'd0);
    check_val("rst_vld16", {15'd0, ov16}, 16'd0);

    // Release without valid must not raise o_vld.
    @(negedge clk);
    rst = 1'b0;
    step();
    check_val("release_vld4", {15'd0, ov4}, 16'd0);
    check_val("release_y4", {12'd0, y4}, 16'd0);

    // Directed rotates.
    dir4("rot1", 4'b1001, 2'd1, 4'b1100);
    dir4("rot2", 4'b0011, 2'd2, 4'b1100);
    dir4("rot3", 4'b1000, 2'd3, 4'b0001);
    dir4("rot0", 4'b1010, 2'd0, 4'b1010);

    // Hold: valid 0110/k=1 then invalid cycles, including unknown inputs.
    dir4("hold_load", 4'b0110, 2'd1, 4'b0011);
    v4 = 1'b0; a4 = 4'b1111; k4 = 2'd2;
    step();
    check_val("hold_y", {12'd0, y4}, 16'h0003);
    check_val("hold_vld", {15'd0, ov4}, 16'd0);
    a4 = 4'bxxxx; k4 = 2'bxx;
    step();
    check_val("hold_x_y", {12'd0, y4}, 16'h0003);
    check_val("hold_x_vld", {15'd0, ov4}, 16'd0);

    // Mid-stream reset between edges clears immediately; an input that is
    // valid at the edges while reset is held is discarded.
    dir4("pre_rst", 4'b1001, 2'd1, 4'b1100);
    a4 = 4'b0101; k4 = 2'd1; v4 = 1'b1;
    #3;
    rst = 1'b1;
    #1;
    check_val("async_rst_y", {12'd0, y4}, 16'd0);
    check_val("async_rst_vld", {15'd0, ov4}, 16'd0);
    step();
    check_val("rst_inflight_y", {12'd0, y4}, 16'd0);
    check_val("rst_inflight_vld", {15'd0, ov4}, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    v4 = 1'b0;
    step();
    check_val("rerelease_vld", {15'd0, ov4}, 16'd0);

    // First valid capture after reset.
    dir4("first_after_rst", 4'b0101, 2'd1, 4'b1010);

    // Exhaustive WIDTH=4 sweep, back-to-back.
    for (int a = 0; a < 16; a++) begin
      for (int k = 0; k < 4; k++) begin
        a4 = 4'(a); k4 = 2'(k); v4 = 1'b1;
        step();
        check_val($sformatf("exh4_a%0d_k%0d", a, k), {12'd0, y4},
                  rot_ref(16'(a), k, 4));
        check_val("exh4_vld", {15'd0, ov4}, 16'd1);
      end
    end

    // Random back-to-back sweeps, all three widths in parallel.
    v8 = 1'b1; v16 = 1'b1;
    for (int n = 0; n < 50; n++) begin
      ra4 = 4'($urandom_range(15, 0));
      rk4 = 2'($urandom_range(3, 0));
      a4 = ra4; k4 = rk4;
      a8 = 8'($urandom_range(255, 0));
      k8 = 3'($urandom_range(7, 0));
      a16 = 16'($urandom_range(65535, 0));
      k16 = 4'($urandom_range(15, 0));
      step();
      check_val($sformatf("rnd4_%0d", n), {12'd0, y4}, rot_ref({12'd0, a4}, int'(k4), 4));
      check_val($sformatf("rnd8_%0d", n), {8'd0, y8}, rot_ref({8'd0, a8}, int'(k8), 8));
      check_val($sformatf("rnd16_%0d", n), y16, rot_ref(a16, int'(k16), 16));
      check_val("rnd16_vld", {15'd0, ov16}, 16'd1);
    end

    // Boundary: maximum rotate amount at WIDTH=16 and WIDTH=8.
    a16 = 16'h8001; k16 = 4'd15; a8 = 8'h81; k8 = 3'd7;
    step();
    check_val("max_k16", y16, 16'h0003);
    check_val("max_k8", {8'd0, y8}, 16'h0003);

    v4 = 1'b0; v8 = 1'b0; v16 = 1'b0;
    step();
    check_val("final_vld16", {15'd0, ov16}, 16'd0);
    check_val("final_hold16", y16, 16'h0003);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
